// File: rtl/reg_file.sv
// reg_file: DEPTH x DATA_W register file with one write port, two registered
// read ports (rd/rs), a per-register busy scoreboard and a valid/ready read
// handshake.
// Optional feature macro: REG_FILE_BYPASS_EN
//   defined   -> same-cycle write data is forwarded to both read ports and a
//                write releases a busy source combinationally in req_ready.
//   undefined -> reads are read-before-write; a busy source stalls until the
//                cycle after its releasing write.
module reg_file #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 2,
    parameter int ZERO_REG = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [ADDR_W-1:0]         waddr,
    input  logic [DATA_W-1:0]         wdata,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_W-1:0]         rd_addr,
    input  logic [ADDR_W-1:0]         rs_addr,
    input  logic                      lock,
    output logic [DATA_W-1:0]         rd_q,
    output logic [DATA_W-1:0]         rs_q,
    output logic                      out_valid,
    output logic [(2**ADDR_W)-1:0]    busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_n;

    logic              write_ok;
    logic              lock_ok;
    logic              accept;
    logic              rd_busy;
    logic              rs_busy;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] rs_val;

    assign busy = busy_q;

    // Index 0 is inert when it is hard-wired to zero: no writes, no locks.
    always_comb begin
        write_ok = we;
        lock_ok  = 1'b1;
        if ((ZERO_REG != 0) && (waddr == '0)) begin
            write_ok = 1'b0;
        end
        if ((ZERO_REG != 0) && (rd_addr == '0)) begin
            lock_ok = 1'b0;
        end
    end

    // A source is busy unless a write to it this cycle is being forwarded.
    always_comb begin
        rd_busy = busy_q[rd_addr];
        rs_busy = busy_q[rs_addr];
`ifdef REG_FILE_BYPASS_EN
        if (we && (waddr == rd_addr)) begin
            rd_busy = 1'b0;
        end
        if (we && (waddr == rs_addr)) begin
            rs_busy = 1'b0;
        end
`endif
        req_ready = !(rd_busy || rs_busy);
        accept    = req_valid && req_ready;
    end

    // Read data selection: stored value, optional forwarding, zero register.
    always_comb begin
        rd_val = regs[rd_addr];
        rs_val = regs[rs_addr];
`ifdef REG_FILE_BYPASS_EN
        if (write_ok && (waddr == rd_addr)) begin
            rd_val = wdata;
        end
        if (write_ok && (waddr == rs_addr)) begin
            rs_val = wdata;
        end
`endif
        if ((ZERO_REG != 0) && (rd_addr == '0)) begin
            rd_val = '0;
        end
        if ((ZERO_REG != 0) && (rs_addr == '0)) begin
            rs_val = '0;
        end
    end

    // Scoreboard update: a write releases, a lock sets; set wins on collision.
    always_comb begin
        busy_n = busy_q;
        if (write_ok) begin
            busy_n[waddr] = 1'b0;
        end
        if (accept && lock && lock_ok) begin
            busy_n[rd_addr] = 1'b1;
        end
    end

    // Register array, scoreboard and read port state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy_q    <= '0;
            rd_q      <= '0;
            rs_q      <= '0;
            out_valid <= 1'b0;
        end else begin
            if (write_ok) begin
                regs[waddr] <= wdata;
            end
            busy_q    <= busy_n;
            out_valid <= accept;
            if (accept) begin
                rd_q <= rd_val;
                rs_q <= rs_val;
            end
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: two reg_file instances (ZERO_REG=0 and ZERO_REG=1) driven by
// the same directed vectors, checked every cycle against a behavioural model
// plus hand-computed literal expectations.
module tb_reg_file;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [1:0]  waddr;
    logic [15:0] wdata;
    logic        req_valid;
    logic [1:0]  rd_addr;
    logic [1:0]  rs_addr;
    logic        lock;

    logic        req_ready [2];
    logic [15:0] rd_q      [2];
    logic [15:0] rs_q      [2];
    logic        out_valid [2];
    logic [3:0]  busy      [2];

    int n_vec  = 0;
    int n_miss = 0;
    bit chk_en = 1'b0;

    // model state, index z selects the ZERO_REG=z instance
    logic [15:0] m_regs  [2][4];
    logic [3:0]  m_busy  [2];
    logic [15:0] m_rd    [2];
    logic [15:0] m_rs    [2];
    logic        m_valid [2];

    always #5 clk = ~clk;

    reg_file #(.DATA_W(16), .ADDR_W(2), .ZERO_REG(0)) u_dut0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .req_valid(req_valid), .req_ready(req_ready[0]),
        .rd_addr(rd_addr), .rs_addr(rs_addr), .lock(lock),
        .rd_q(rd_q[0]), .rs_q(rs_q[0]), .out_valid(out_valid[0]),
        .busy(busy[0])
    );

    reg_file #(.DATA_W(16), .ADDR_W(2), .ZERO_REG(1)) u_dut1 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .req_valid(req_valid), .req_ready(req_ready[1]),
        .rd_addr(rd_addr), .rs_addr(rs_addr), .lock(lock),
        .rd_q(rd_q[1]), .rs_q(rs_q[1]), .out_valid(out_valid[1]),
        .busy(busy[1])
    );

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic m_src_busy(int z, logic [1:0] i);
        return m_busy[z][i] && !(BYP && we && (waddr == i));
    endfunction

    function automatic logic m_ready(int z);
        return !(m_src_busy(z, rd_addr) || m_src_busy(z, rs_addr));
    endfunction

    function automatic logic [15:0] m_read(int z, logic [1:0] i);
        if (z == 1 && i == 2'd0) return 16'h0000;
        if (BYP && we && (waddr == i)) return wdata;
        return m_regs[z][i];
    endfunction

    // model: advance both instances on each rising edge
    always @(posedge clk) begin
        for (int z = 0; z < 2; z++) begin
            if (rst) begin
                for (int i = 0; i < 4; i++) m_regs[z][i] = 16'h0000;
                m_busy[z]  = 4'b0000;
                m_rd[z]    = 16'h0000;
                m_rs[z]    = 16'h0000;
                m_valid[z] = 1'b0;
            end else begin
                logic acc;
                acc = req_valid && m_ready(z);
                if (acc) begin
                    m_rd[z] = m_read(z, rd_addr);
                    m_rs[z] = m_read(z, rs_addr);
                end
                m_valid[z] = acc;
                if (we && !(z == 1 && waddr == 2'd0)) begin
                    m_regs[z][waddr] = wdata;
                    m_busy[z][waddr] = 1'b0;
                end
                if (acc && lock && !(z == 1 && rd_addr == 2'd0))
                    m_busy[z][rd_addr] = 1'b1;
            end
        end
    end

    // compare process: mid-cycle check of every output of both instances
    always @(negedge clk) begin
        if (chk_en) begin
            for (int z = 0; z < 2; z++) begin
                checkOutput($sformatf("z%0d rd_q", z), 32'(rd_q[z]), 32'(m_rd[z]));
                checkOutput($sformatf("z%0d rs_q", z), 32'(rs_q[z]), 32'(m_rs[z]));
                checkOutput($sformatf("z%0d out_valid", z), 32'(out_valid[z]), 32'(m_valid[z]));
                checkOutput($sformatf("z%0d busy", z), 32'(busy[z]), 32'(m_busy[z]));
                if (!rst)
                    checkOutput($sformatf("z%0d req_ready", z), 32'(req_ready[z]), 32'(m_ready(z)));
            end
        end
    end

    task automatic driveInputs(input logic w, input logic [1:0] wa, input logic [15:0] wd,
                               input logic v, input logic [1:0] ra, input logic [1:0] sa,
                               input logic lk);
        we = w; waddr = wa; wdata = wd;
        req_valid = v; rd_addr = ra; rs_addr = sa; lock = lk;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic w, input logic [1:0] wa, input logic [15:0] wd,
                                 input logic v, input logic [1:0] ra, input logic [1:0] sa,
                                 input logic lk);
        driveInputs(w, wa, wd, v, ra, sa, lk);
        stepClock();
    endtask

    initial begin
        int cycles;
        rst = 1'b1;
        driveInputs(0, 0, 0, 0, 0, 0, 0);
        stepClock();
        chk_en = 1'b1;
        stepClock();
        rst = 1'b0;

        // reset then read
        applyStimulus(0, 0, 0, 1, 2, 3, 0);
        checkOutput("rst_read out_valid", 32'(out_valid[0]), 32'd1);
        checkOutput("rst_read rd_q", 32'(rd_q[0]), 32'h0);
        checkOutput("rst_read rs_q", 32'(rs_q[0]), 32'h0);
        checkOutput("rst_read busy", 32'(busy[0]), 32'h0);

        // write then read
        applyStimulus(1, 1, 16'hA5A5, 0, 0, 0, 0);
        checkOutput("pulse end", 32'(out_valid[0]), 32'd0);
        applyStimulus(0, 0, 0, 1, 1, 1, 0);
        checkOutput("wr_rd rd_q", 32'(rd_q[0]), 32'hA5A5);
        checkOutput("wr_rd rs_q", 32'(rs_q[0]), 32'hA5A5);
        checkOutput("wr_rd out_valid", 32'(out_valid[0]), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("wr_rd pulse", 32'(out_valid[0]), 32'd0);

        // lock stall and release
        applyStimulus(0, 0, 0, 1, 2, 0, 1);
        driveInputs(0, 0, 0, 1, 0, 2, 0);
        #1;
        checkOutput("lock ready", 32'(req_ready[0]), 32'd0);
        checkOutput("lock busy2", 32'(busy[0][2]), 32'd1);
        stepClock();
        cycles = 0;
        for (int k = 0; k < 6; k++) begin
            if (k == 0) driveInputs(1, 2, 16'h1234, 1, 0, 2, 0);
            else        driveInputs(0, 0, 0, 1, 0, 2, 0);
            stepClock();
            cycles++;
            if (out_valid[0]) break;
        end
        checkOutput("stall cycles", 32'(cycles), BYP ? 32'd1 : 32'd2);
        checkOutput("stall rs_q", 32'(rs_q[0]), 32'h1234);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // same-cycle write/read collision
        applyStimulus(1, 3, 16'h0F0F, 0, 0, 0, 0);
        applyStimulus(1, 3, 16'h00FF, 1, 3, 1, 0);
        checkOutput("collide rd_q", 32'(rd_q[0]), BYP ? 32'h00FF : 32'h0F0F);
        checkOutput("collide rs_q", 32'(rs_q[0]), 32'hA5A5);
        applyStimulus(1, 3, 16'h5555, 1, 3, 0, 1);
        checkOutput("lockwr busy3", 32'(busy[0][3]), 32'd1);
        applyStimulus(1, 3, 16'h6666, 0, 0, 0, 0);
        checkOutput("release busy3", 32'(busy[0][3]), 32'd0);

        // mid-operation reset
        applyStimulus(0, 0, 0, 1, 1, 0, 1);
        applyStimulus(0, 0, 0, 1, 2, 0, 1);
        checkOutput("pre_rst busy", 32'(busy[0]), 32'b0110);
        rst = 1'b1;
        applyStimulus(1, 3, 16'hBEEF, 1, 3, 0, 0);
        rst = 1'b0;
        checkOutput("mid_rst busy", 32'(busy[0]), 32'h0);
        checkOutput("mid_rst out_valid", 32'(out_valid[0]), 32'd0);
        checkOutput("mid_rst rd_q", 32'(rd_q[0]), 32'h0);
        applyStimulus(0, 0, 0, 1, 1, 3, 0);
        checkOutput("post_rst rd_q", 32'(rd_q[0]), 32'h0);
        checkOutput("post_rst rs_q", 32'(rs_q[0]), 32'h0);

        // hard-wired zero register (instance 1)
        driveInputs(1, 0, 16'hFFFF, 1, 0, 0, 1);
        #1;
        checkOutput("zero ready", 32'(req_ready[1]), 32'd1);
        stepClock();
        checkOutput("zero busy0", 32'(busy[1][0]), 32'd0);
        checkOutput("zero rd_q", 32'(rd_q[1]), 32'h0);
        driveInputs(0, 0, 0, 1, 0, 0, 0);
        #1;
        checkOutput("zero ready2", 32'(req_ready[1]), 32'd1);
        checkOutput("nozero busy0", 32'(busy[0][0]), 32'd1);
        stepClock();
        checkOutput("zero rd_q2", 32'(rd_q[1]), 32'h0);

        // sweep: fill every register, then read all pairs
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 2'(i), 16'(16'h1000 + 16'h0111 * i), 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                applyStimulus(0, 0, 0, 1, 2'(i), 2'(j), 0);
        checkOutput("sweep rd_q", 32'(rd_q[0]), 32'h1333);
        checkOutput("sweep rs_q z1", 32'(rs_q[1]), 32'h1333);
        applyStimulus(0, 0, 0, 1, 0, 2, 0);
        checkOutput("sweep zero", 32'(rd_q[1]), 32'h0);
        checkOutput("sweep nozero", 32'(rd_q[0]), 32'h1000);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
